udt_rx_demux: RTL and testbench

Receive-side packet classifier for the UDT core. Accepts the UDP payload stream and buffers the 16-byte UDT header. It then routes each whole packet to one of three AXI-Stream outputs:
- handshake control packets go to the listen/connection stage through its `handshake_*` input;
- all other control packets go to the control-processing stage;
- data packets go to the receive buffer.

Runt and unsupported packets are discarded and counted.

---
 rtl/udt_pkg.sv | 39 +++
 rtl/udt_sat_cnt16.sv | 17 +
 rtl/udt_rx_demux.sv | 182 ++++++++++++++++++
 tb/tb_udt_rx_demux.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udt_pkg.sv
// Shared types and constants for the UDT receive path: routing/state enums,
// control-type codes, header word indices and the word0 classifier.
package udt_pkg;

  typedef enum logic [1:0] {NONE, HS, CTRL, DATA} udt_route_e;
  typedef enum logic [1:0] {HDR, DRAIN, PASS, DROP} rx_state_e;

  localparam logic [14:0] UDT_CT_HANDSHAKE = 15'h0000;
  localparam logic [14:0] UDT_CT_KEEPALIVE = 15'h0001;
  localparam logic [14:0] UDT_CT_ACK       = 15'h0002;
  localparam logic [14:0] UDT_CT_NAK       = 15'h0003;
  localparam logic [14:0] UDT_CT_CONG      = 15'h0004;
  localparam logic [14:0] UDT_CT_SHUTDOWN  = 15'h0005;
  localparam logic [14:0] UDT_CT_ACK2      = 15'h0006;
  localparam logic [14:0] UDT_CT_MSGDROP   = 15'h0007;
  localparam logic [14:0] UDT_CT_USER      = 15'h7FFF;

  localparam logic [1:0] HDR_WORD0 = 2'd0;
  localparam logic [1:0] HDR_SOCK  = 2'd3;

  // Classify from the upper half of word0: flag bit plus 15-bit control type.
  function automatic udt_route_e udt_classify(input logic [15:0] w0_hi);
    udt_route_e r;
    r = NONE;
    if (!w0_hi[15]) begin
      r = DATA;
    end else begin
      case (w0_hi[14:0])
        UDT_CT_HANDSHAKE: r = HS;
        UDT_CT_KEEPALIVE, UDT_CT_ACK, UDT_CT_NAK, UDT_CT_CONG,
        UDT_CT_SHUTDOWN, UDT_CT_ACK2, UDT_CT_MSGDROP: r = CTRL;
        UDT_CT_USER: r = NONE;
        default: r = NONE;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/udt_sat_cnt16.sv
// 16-bit event counter that sticks at 0xFFFF.
module udt_sat_cnt16 (
  input  logic        clk,
  input  logic        core_rst,
  input  logic        inc,
  output logic [15:0] count
);

  always_ff @(posedge clk) begin
    if (core_rst) begin
      count <= 16'd0;
    end else if (inc && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/udt_rx_demux.sv
// UDT receive classifier: buffers the 4-word header, then routes the packet to
// handshake/control/data streams or sinks it. Optional UDT_RX_SOCKID_FILTER_EN.
module udt_rx_demux
  import udt_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int KEEP_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              core_rst,
  input  logic [DATA_W-1:0] rx_tdata,
  input  logic [KEEP_W-1:0] rx_tkeep,
  input  logic              rx_tvalid,
  input  logic              rx_tlast,
  output logic              rx_tready,
  output logic [DATA_W-1:0] handshake_tdata,
  output logic [KEEP_W-1:0] handshake_tkeep,
  output logic              handshake_tvalid,
  output logic              handshake_tlast,
  input  logic              handshake_tready,
  output logic [DATA_W-1:0] ctrl_tdata,
  output logic [KEEP_W-1:0] ctrl_tkeep,
  output logic              ctrl_tvalid,
  output logic              ctrl_tlast,
  input  logic              ctrl_tready,
  output logic [DATA_W-1:0] data_tdata,
  output logic [KEEP_W-1:0] data_tkeep,
  output logic              data_tvalid,
  output logic              data_tlast,
  input  logic              data_tready,
  input  logic [31:0]       local_sock_id,
  output logic [15:0]       rx_pkt_cnt,
  output logic [15:0]       drop_cnt,
  output rx_state_e         state
);

  // Handshake rule on every stream: a beat transfers on a cycle where
  // tvalid && tready are both high at the rising edge of clk.
  rx_state_e         state_q;
  logic [1:0]        cnt;
  udt_route_e        route;
  udt_route_e        next_route;
  logic              hdr_last;
  logic [DATA_W-1:0] hdr [4];

  logic              accept;
  logic              sel_ready;
  logic              out_valid;
  logic              out_last;
  logic [DATA_W-1:0] out_data;
  logic [KEEP_W-1:0] out_keep;
  logic              rx_inc;
  logic              drop_inc;

  assign state  = state_q;
  assign accept = rx_tvalid && rx_tready;

  always_comb begin
    next_route = udt_classify(hdr[HDR_WORD0][31:16]);
`ifdef UDT_RX_SOCKID_FILTER_EN
    // Word3 is still on rx_tdata at the decision beat.
    if (!((rx_tdata == local_sock_id) || (next_route == HS && rx_tdata == '0)))
      next_route = NONE;
`endif
  end

`ifndef UDT_RX_SOCKID_FILTER_EN
  logic unused_sock_id;
  assign unused_sock_id = ^local_sock_id;
`endif

  always_comb begin
    sel_ready = 1'b0;
    case (route)
      HS:      sel_ready = handshake_tready;
      CTRL:    sel_ready = ctrl_tready;
      DATA:    sel_ready = data_tready;
      default: sel_ready = 1'b0;
    endcase
  end

  always_comb begin
    rx_tready = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    out_keep  = '0;
    if (!core_rst) begin
      case (state_q)
        HDR: rx_tready = 1'b1;
        DRAIN: begin
          out_valid = 1'b1;
          out_data  = hdr[cnt];
          out_keep  = '1;
          out_last  = (cnt == HDR_SOCK) && hdr_last;
        end
        PASS: begin
          out_valid = rx_tvalid;
          out_data  = rx_tdata;
          out_keep  = rx_tkeep;
          out_last  = rx_tlast;
          rx_tready = sel_ready;
        end
        // With the packet already ended, hold off so the next word0 is not sunk.
        DROP: rx_tready = !hdr_last;
        default: rx_tready = 1'b0;
      endcase
    end
  end

  always_comb begin
    handshake_tvalid = 1'b0; handshake_tdata = '0; handshake_tkeep = '0; handshake_tlast = 1'b0;
    ctrl_tvalid      = 1'b0; ctrl_tdata      = '0; ctrl_tkeep      = '0; ctrl_tlast      = 1'b0;
    data_tvalid      = 1'b0; data_tdata      = '0; data_tkeep      = '0; data_tlast      = 1'b0;
    case (route)
      HS: begin
        handshake_tvalid = out_valid; handshake_tdata = out_data;
        handshake_tkeep  = out_keep;  handshake_tlast = out_last;
      end
      CTRL: begin
        ctrl_tvalid = out_valid; ctrl_tdata = out_data;
        ctrl_tkeep  = out_keep;  ctrl_tlast = out_last;
      end
      DATA: begin
        data_tvalid = out_valid; data_tdata = out_data;
        data_tkeep  = out_keep;  data_tlast = out_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (core_rst) begin
      state_q  <= HDR;
      cnt      <= 2'd0;
      route    <= NONE;
      hdr_last <= 1'b0;
    end else begin
      case (state_q)
        HDR: if (accept) begin
          hdr[cnt] <= rx_tdata;
          if (cnt == HDR_SOCK) begin
            route    <= next_route;
            hdr_last <= rx_tlast;
            cnt      <= 2'd0;
            state_q  <= (next_route == NONE) ? DROP : DRAIN;
          end else if (rx_tlast) begin
            cnt <= 2'd0;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        DRAIN: if (sel_ready) begin
          cnt <= cnt + 2'd1;
          if (cnt == HDR_SOCK) state_q <= hdr_last ? HDR : PASS;
        end
        PASS: if (accept && rx_tlast) state_q <= HDR;
        DROP: if (hdr_last || (accept && rx_tlast)) state_q <= HDR;
        default: state_q <= HDR;
      endcase
    end
  end

  assign rx_inc   = accept && rx_tlast;
  assign drop_inc = ((state_q == HDR) && accept && rx_tlast && (cnt != HDR_SOCK)) ||
                    ((state_q == DROP) && (hdr_last || (accept && rx_tlast)));

  udt_sat_cnt16 u_rx_cnt (
    .clk      (clk),
    .core_rst (core_rst),
    .inc      (rx_inc),
    .count    (rx_pkt_cnt)
  );

  udt_sat_cnt16 u_drop_cnt (
    .clk      (clk),
    .core_rst (core_rst),
    .inc      (drop_inc),
    .count    (drop_cnt)
  );

endmodule

// File: tb/tb_udt_rx_demux.sv
// Bench for udt_rx_demux: per-output expected queues fed by the packet driver
// and drained by a negedge monitor; counters checked against a reference model.
module tb_udt_rx_demux;
  import udt_pkg::*;

  localparam int W = 37; // {keep, last, data}

  logic        clk = 1'b0;
  logic        core_rst = 1'b1;
  logic [31:0] rx_tdata = '0;
  logic [3:0]  rx_tkeep = '0;
  logic        rx_tvalid = 1'b0;
  logic        rx_tlast = 1'b0;
  logic        rx_tready;
  logic [31:0] handshake_tdata, ctrl_tdata, data_tdata;
  logic [3:0]  handshake_tkeep, ctrl_tkeep, data_tkeep;
  logic        handshake_tvalid, ctrl_tvalid, data_tvalid;
  logic        handshake_tlast, ctrl_tlast, data_tlast;
  logic        handshake_tready = 1'b1;
  logic        ctrl_tready = 1'b1;
  logic        data_tready = 1'b1;
  logic [31:0] local_sock_id = 32'h0000_1234;
  logic [15:0] rx_pkt_cnt, drop_cnt;
  rx_state_e   state;

  udt_rx_demux dut (
    .clk(clk), .core_rst(core_rst),
    .rx_tdata(rx_tdata), .rx_tkeep(rx_tkeep), .rx_tvalid(rx_tvalid),
    .rx_tlast(rx_tlast), .rx_tready(rx_tready),
    .handshake_tdata(handshake_tdata), .handshake_tkeep(handshake_tkeep),
    .handshake_tvalid(handshake_tvalid), .handshake_tlast(handshake_tlast),
    .handshake_tready(handshake_tready),
    .ctrl_tdata(ctrl_tdata), .ctrl_tkeep(ctrl_tkeep), .ctrl_tvalid(ctrl_tvalid),
    .ctrl_tlast(ctrl_tlast), .ctrl_tready(ctrl_tready),
    .data_tdata(data_tdata), .data_tkeep(data_tkeep), .data_tvalid(data_tvalid),
    .data_tlast(data_tlast), .data_tready(data_tready),
    .local_sock_id(local_sock_id), .rx_pkt_cnt(rx_pkt_cnt), .drop_cnt(drop_cnt),
    .state(state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] hs_q[$];
  logic [W-1:0] ctrl_q[$];
  logic [W-1:0] exp_q[$]; // data stream
  int exp_rx = 0;
  int exp_drop = 0;
  bit bp_en = 1'b0;
  int last_wait = 0;
  int first_wait = 0;
  logic [31:0] pkt_w [64];
  logic [3:0]  pkt_k [64];

  always @(posedge clk) begin
    #1;
    data_tready = bp_en ? ~data_tready : 1'b1;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int model_route(input logic [31:0] w0, input logic [31:0] w3);
    int r;
    int t;
    t = int'(w0[30:16]);
    if (!w0[31]) r = 3;
    else if (t == 0) r = 1;
    else if (t <= 7) r = 2;
    else r = 0;
`ifdef UDT_RX_SOCKID_FILTER_EN
    if (!(w3 == local_sock_id || (r == 1 && w3 == 32'h0))) r = 0;
`else
    if (w3 === 32'hx) r = r; // word3 does not affect routing here
`endif
    return r;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!core_rst) begin
      if (handshake_tvalid && handshake_tready) begin
        tests++;
        if (hs_q.size() == 0) begin
          fails++;
          $display("FAIL hs_unexpected got=%h", handshake_tdata);
        end else begin
          e = hs_q.pop_front();
          if ({handshake_tkeep, handshake_tlast, handshake_tdata} !== e) begin
            fails++;
            $display("FAIL hs_beat got=%h exp=%h", {handshake_tkeep, handshake_tlast, handshake_tdata}, e);
          end
        end
      end
      if (ctrl_tvalid && ctrl_tready) begin
        tests++;
        if (ctrl_q.size() == 0) begin
          fails++;
          $display("FAIL ctrl_unexpected got=%h", ctrl_tdata);
        end else begin
          e = ctrl_q.pop_front();
          if ({ctrl_tkeep, ctrl_tlast, ctrl_tdata} !== e) begin
            fails++;
            $display("FAIL ctrl_beat got=%h exp=%h", {ctrl_tkeep, ctrl_tlast, ctrl_tdata}, e);
          end
        end
      end
      if (data_tvalid && data_tready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL data_unexpected got=%h", data_tdata);
        end else begin
          e = exp_q.pop_front();
          if ({data_tkeep, data_tlast, data_tdata} !== e) begin
            fails++;
            $display("FAIL data_beat got=%h exp=%h", {data_tkeep, data_tlast, data_tdata}, e);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    core_rst = 1'b1;
    rx_tvalid = 1'b0;
    rx_tlast = 1'b0;
    hs_q.delete(); ctrl_q.delete(); exp_q.delete();
    exp_rx = 0; exp_drop = 0;
    repeat (2) @(posedge clk);
    #1 core_rst = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int w;
    w = 0;
    rx_tdata = d; rx_tkeep = k; rx_tlast = l; rx_tvalid = 1'b1;
    @(negedge clk);
    while (!rx_tready && w < 200) begin
      w++;
      @(negedge clk);
    end
    last_wait = w;
    if (w >= 200) begin
      tests++; fails++;
      $display("FAIL rx_tready_timeout waited=%0d limit=200", w);
    end
    @(posedge clk);
    #1;
    rx_tvalid = 1'b0;
    rx_tlast = 1'b0;
  endtask

  task automatic make_pkt(input logic [31:0] w0, input int len);
    for (int i = 0; i < len; i++) begin
      pkt_w[i] = $urandom;
      pkt_k[i] = 4'hF;
    end
    pkt_w[0] = w0;
    pkt_w[3] = 32'h0000_1234;
  endtask

  task automatic send_pkt(input int len);
    int r;
    logic [W-1:0] e;
    exp_rx++;
    if (len < 4) begin
      exp_drop++;
    end else begin
      r = model_route(pkt_w[0], pkt_w[3]);
      if (r == 0) exp_drop++;
      for (int i = 0; i < len; i++) begin
        e = {(i < 4) ? 4'hF : pkt_k[i], (i == len - 1), pkt_w[i]};
        if (r == 1) hs_q.push_back(e);
        else if (r == 2) ctrl_q.push_back(e);
        else if (r == 3) exp_q.push_back(e);
      end
    end
    for (int i = 0; i < len; i++) begin
      send_beat(pkt_w[i], pkt_k[i], (i == len - 1));
      if (i == 0) first_wait = last_wait;
    end
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while ((hs_q.size() + ctrl_q.size() + exp_q.size()) != 0 && w < 400) begin
      @(posedge clk);
      w++;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    core_rst = 1'b1;
    rx_tvalid = 1'b1;
    rx_tdata = 32'h8000_0000;
    rx_tlast = 1'b1;
    @(negedge clk);
    tests++;
    if (rx_tready !== 1'b0) begin fails++; $display("FAIL reset_rx_tready got=%b exp=0", rx_tready); end
    tests++;
    if ({handshake_tvalid, ctrl_tvalid, data_tvalid} !== 3'b000) begin
      fails++; $display("FAIL reset_valids got=%b exp=000", {handshake_tvalid, ctrl_tvalid, data_tvalid});
    end
    rx_tvalid = 1'b0;
    rx_tlast = 1'b0;
    @(posedge clk);
    #1 core_rst = 1'b0;
    @(negedge clk);
    tests++;
    if (rx_tready !== 1'b1) begin fails++; $display("FAIL post_reset_rx_tready got=%b exp=1", rx_tready); end
    tests++;
    if (rx_pkt_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
      fails++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", rx_pkt_cnt, drop_cnt);
    end
  endtask

  task automatic test_handshake();
    apply_reset();
    make_pkt(32'h8000_0000, 16);
    send_pkt(16);
    wait_drain();
    tests++;
    if (hs_q.size() != 0) begin fails++; $display("FAIL hs_missing left=%0d exp=0", hs_q.size()); end
    tests++;
    if (rx_pkt_cnt !== 16'd1 || drop_cnt !== 16'd0) begin
      fails++; $display("FAIL hs_counters got=%0d/%0d exp=1/0", rx_pkt_cnt, drop_cnt);
    end
  endtask

  task automatic test_keepalive();
    apply_reset();
    make_pkt(32'h8001_0000, 4);
    send_pkt(4);
    make_pkt(32'h0000_0005, 6);
    send_pkt(6);
    tests++;
    if (first_wait != 4) begin fails++; $display("FAIL ka_next_pkt_stall got=%0d exp=4", first_wait); end
    wait_drain();
    tests++;
    if (ctrl_q.size() + exp_q.size() != 0) begin
      fails++; $display("FAIL ka_missing left=%0d exp=0", ctrl_q.size() + exp_q.size());
    end
    tests++;
    if (rx_pkt_cnt !== 16'(exp_rx) || drop_cnt !== 16'(exp_drop)) begin
      fails++; $display("FAIL ka_counters got=%0d/%0d exp=%0d/%0d", rx_pkt_cnt, drop_cnt, exp_rx, exp_drop);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    bp_en = 1'b1;
    make_pkt(32'h0000_0010, 10);
    pkt_k[9] = 4'h3;
    send_pkt(10);
    wait_drain();
    bp_en = 1'b0;
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL bp_missing left=%0d exp=0", exp_q.size()); end
    tests++;
    if (rx_pkt_cnt !== 16'd1 || drop_cnt !== 16'd0) begin
      fails++; $display("FAIL bp_counters got=%0d/%0d exp=1/0", rx_pkt_cnt, drop_cnt);
    end
  endtask

  task automatic test_runt_unknown();
    apply_reset();
    make_pkt(32'h8002_0000, 2);
    send_pkt(2);
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (drop_cnt !== 16'd1) begin fails++; $display("FAIL runt_drop got=%0d exp=1", drop_cnt); end
    make_pkt(32'h8009_0000, 8);
    send_pkt(8);
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (drop_cnt !== 16'd2) begin fails++; $display("FAIL unknown_drop got=%0d exp=2", drop_cnt); end
    // Header-only user-type packet, immediately followed by an ACK whose word3 keep is partial.
    make_pkt(32'hFFFF_0000, 4);
    send_pkt(4);
    make_pkt(32'h8002_0000, 4);
    pkt_k[3] = 4'h3;
    send_pkt(4);
    wait_drain();
    tests++;
    if (ctrl_q.size() != 0) begin fails++; $display("FAIL short_ack_missing left=%0d exp=0", ctrl_q.size()); end
    tests++;
    if (rx_pkt_cnt !== 16'(exp_rx) || drop_cnt !== 16'(exp_drop)) begin
      fails++; $display("FAIL runt_counters got=%0d/%0d exp=%0d/%0d", rx_pkt_cnt, drop_cnt, exp_rx, exp_drop);
    end
  endtask

  task automatic test_back_to_back();
    int len;
    logic [31:0] w0;
    apply_reset();
    make_pkt(32'h8000_0000, 8);
    send_pkt(8);
    make_pkt(32'h0000_0001, 5);
    send_pkt(5);
    tests++;
    if (first_wait != 0) begin fails++; $display("FAIL b2b_word0_stall got=%0d exp=0", first_wait); end
    for (int n = 0; n < 24; n++) begin
      bp_en = ($urandom_range(0, 1) == 1);
      len = $urandom_range(1, 12);
      case ($urandom_range(0, 4))
        0: w0 = {16'h8000, 16'($urandom)};
        1: w0 = {1'b1, 15'($urandom_range(1, 7)), 16'($urandom)};
        2: w0 = {1'b1, 15'($urandom_range(8, 32766)), 16'($urandom)};
        3: w0 = {16'hFFFF, 16'($urandom)};
        default: w0 = {1'b0, 31'($urandom)};
      endcase
      make_pkt(w0, len);
      send_pkt(len);
    end
    wait_drain();
    bp_en = 1'b0;
    tests++;
    if (hs_q.size() + ctrl_q.size() + exp_q.size() != 0) begin
      fails++; $display("FAIL b2b_missing left=%0d exp=0", hs_q.size() + ctrl_q.size() + exp_q.size());
    end
    tests++;
    if (rx_pkt_cnt !== 16'(exp_rx) || drop_cnt !== 16'(exp_drop)) begin
      fails++; $display("FAIL b2b_counters got=%0d/%0d exp=%0d/%0d", rx_pkt_cnt, drop_cnt, exp_rx, exp_drop);
    end
  endtask

  task automatic test_reset_mid_pass();
    apply_reset();
    make_pkt(32'h0000_0020, 10);
    for (int i = 0; i < 5; i++) exp_q.push_back({4'hF, 1'b0, pkt_w[i]});
    for (int i = 0; i < 5; i++) send_beat(pkt_w[i], pkt_k[i], 1'b0);
    rx_tdata = pkt_w[5]; rx_tkeep = 4'hF; rx_tvalid = 1'b1;
    core_rst = 1'b1;
    @(posedge clk);
    #1;
    core_rst = 1'b0;
    rx_tvalid = 1'b0;
    exp_rx = 0; exp_drop = 0;
    make_pkt(32'h8001_0000, 4);
    send_pkt(4);
    wait_drain();
    tests++;
    if (ctrl_q.size() + exp_q.size() != 0) begin
      fails++; $display("FAIL rst_mid_missing left=%0d exp=0", ctrl_q.size() + exp_q.size());
    end
    tests++;
    if (rx_pkt_cnt !== 16'd1 || drop_cnt !== 16'd0) begin
      fails++; $display("FAIL rst_mid_counters got=%0d/%0d exp=1/0", rx_pkt_cnt, drop_cnt);
    end
  endtask

`ifdef UDT_RX_SOCKID_FILTER_EN
  task automatic test_sockid_filter();
    apply_reset();
    make_pkt(32'h8000_0000, 6);
    pkt_w[3] = 32'h0;
    send_pkt(6);
    make_pkt(32'h8002_0000, 4);
    pkt_w[3] = 32'h0000_1234;
    send_pkt(4);
    make_pkt(32'h8002_0000, 4);
    pkt_w[3] = 32'h0000_9999;
    send_pkt(4);
    wait_drain();
    tests++;
    if (hs_q.size() + ctrl_q.size() != 0) begin
      fails++; $display("FAIL filter_missing left=%0d exp=0", hs_q.size() + ctrl_q.size());
    end
    tests++;
    if (drop_cnt !== 16'd1 || rx_pkt_cnt !== 16'd3) begin
      fails++; $display("FAIL filter_counters got=%0d/%0d exp=3/1", rx_pkt_cnt, drop_cnt);
    end
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_handshake();
    test_keepalive();
    test_backpressure();
    test_runt_unknown();
    test_back_to_back();
    test_reset_mid_pass();
`ifdef UDT_RX_SOCKID_FILTER_EN
    test_sockid_filter();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
